// File: rtl/fp_align_27b.sv
// Operand-alignment stage for the single-precision add/sub path: unpack, swap, shift with guard/sticky, negate.
// Optional FPU_ALIGN_DENORM_EN: exp==0 operands are subnormals (sig {0,mant}, e=1); otherwise flushed to signed zero.
module fp_align_27b (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] frac1,
    output logic [26:0] frac2,
    output logic [7:0]  exp_out,
    output logic        special
);

    typedef struct packed {
        logic [23:0] sig;
        logic [7:0]  e;
    } unpacked_t;

    function automatic unpacked_t unpack(input logic [31:0] op);
        unpacked_t u;
        if (op[30:23] == 8'd0) begin
`ifdef FPU_ALIGN_DENORM_EN
            u.sig = {1'b0, op[22:0]};
            u.e   = 8'd1;
`else
            u.sig = 24'd0;
            u.e   = 8'd0;
`endif
        end else begin
            u.sig = {1'b1, op[22:0]};
            u.e   = op[30:23];
        end
        return u;
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: unpack and compare exponents ----------------
    unpacked_t ua;
    unpacked_t ub;
    logic      n_swap;
    logic [7:0] n_e_large;
    logic [7:0] n_d;
    logic      n_special;

    always_comb begin
        ua        = unpack(op_a);
        ub        = unpack(op_b);
        // Ties keep A as the large operand.
        n_swap    = ub.e > ua.e;
        n_e_large = n_swap ? ub.e : ua.e;
        n_d       = n_swap ? (ub.e - ua.e) : (ua.e - ub.e);
        n_special = (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
    end

    logic        s1_sign_a;
    logic        s1_sign_b;
    logic [23:0] s1_sig_a;
    logic [23:0] s1_sig_b;
    logic [7:0]  s1_e_large;
    logic [7:0]  s1_d;
    logic        s1_swap;
    logic        s1_special;

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: datapath flops are reset too so outputs read as zero before the first result.
        if (!nRST) begin
            s1_valid   <= 1'b0;
            s1_sign_a  <= 1'b0;
            s1_sign_b  <= 1'b0;
            s1_sig_a   <= 24'd0;
            s1_sig_b   <= 24'd0;
            s1_e_large <= 8'd0;
            s1_d       <= 8'd0;
            s1_swap    <= 1'b0;
            s1_special <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign_a  <= op_a[31];
                s1_sign_b  <= op_b[31] ^ sub;
                s1_sig_a   <= ua.sig;
                s1_sig_b   <= ub.sig;
                s1_e_large <= n_e_large;
                s1_d       <= n_d;
                s1_swap    <= n_swap;
                s1_special <= n_special;
            end
        end
    end

    // ---------------- stage 2: shift, sticky, negate ----------------
    logic        sign_l;
    logic        sign_s;
    logic [25:0] m_l;
    logic [25:0] m_s;
    logic [25:0] shifted;
    logic        lost;
    logic [25:0] word_s;
    logic [26:0] f_l;
    logic [26:0] f_s;
    logic [26:0] n_frac1;
    logic [26:0] n_frac2;
    logic [7:0]  n_exp;

    always_comb begin
        sign_l  = s1_swap ? s1_sign_b : s1_sign_a;
        sign_s  = s1_swap ? s1_sign_a : s1_sign_b;
        m_l     = {(s1_swap ? s1_sig_b : s1_sig_a), 2'b00};
        m_s     = {(s1_swap ? s1_sig_a : s1_sig_b), 2'b00};
        shifted = 26'd0;
        lost    = 1'b0;
        if (s1_d >= 8'd26) begin
            word_s = {25'd0, |m_s};
        end else begin
            shifted = m_s >> s1_d;
            // Bits pushed past bit 0 all fold into sticky.
            lost    = |(m_s & ~(26'h3FF_FFFF << s1_d));
            word_s  = {shifted[25:1], shifted[0] | lost};
        end
        f_l     = {1'b0, m_l};
        f_s     = {1'b0, word_s};
        n_frac1 = sign_l ? (27'd0 - f_l) : f_l;
        n_frac2 = sign_s ? (27'd0 - f_s) : f_s;
        n_exp   = s1_e_large;
        if (s1_special) begin
            n_frac1 = 27'd0;
            n_frac2 = 27'd0;
            n_exp   = 8'hFF;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            frac1     <= 27'd0;
            frac2     <= 27'd0;
            exp_out   <= 8'd0;
            special   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                frac1   <= n_frac1;
                frac2   <= n_frac2;
                exp_out <= n_exp;
                special <= s1_special;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_27b.sv
// Self-checking bench for fp_align_27b: vector table, backpressure, reset and random traffic against a scoreboard.
module tb_fp_align_27b;

    typedef logic [62:0] res_t;  // {special, exp_out, frac1, frac2}

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        res_t        exp;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] frac1;
    logic [26:0] frac2;
    logic [7:0]  exp_out;
    logic        special;

    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 0;
    res_t exp_q[$];
    vec_t vecs[12];

    fp_align_27b dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frac1     (frac1),
        .frac2     (frac2),
        .exp_out   (exp_out),
        .special   (special)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic res_t mk(input logic sp, input logic [7:0] e, input logic [26:0] f1, input logic [26:0] f2);
        return {sp, e, f1, f2};
    endfunction

    // Reference model written bit-serially from the operation description.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [7:0]  ea = a[30:23];
        logic [7:0]  eb = b[30:23];
        logic [23:0] ma = {1'b1, a[22:0]};
        logic [23:0] mb = {1'b1, b[22:0]};
        logic        sa = a[31];
        logic        sb = b[31] ^ s;
        logic [7:0]  el;
        logic [7:0]  dd;
        logic [25:0] wl;
        logic [25:0] ws;
        logic        sl;
        logic        ss;
        logic        st = 1'b0;
        logic [26:0] fl;
        logic [26:0] fs;
        if (ea == 8'hFF || eb == 8'hFF) return mk(1'b1, 8'hFF, 27'd0, 27'd0);
`ifdef FPU_ALIGN_DENORM_EN
        if (ea == 8'd0) begin ma = {1'b0, a[22:0]}; ea = 8'd1; end
        if (eb == 8'd0) begin mb = {1'b0, b[22:0]}; eb = 8'd1; end
`else
        if (ea == 8'd0) ma = 24'd0;
        if (eb == 8'd0) mb = 24'd0;
`endif
        if (eb > ea) begin
            el = eb; dd = eb - ea; wl = {mb, 2'b00}; ws = {ma, 2'b00}; sl = sb; ss = sa;
        end else begin
            el = ea; dd = ea - eb; wl = {ma, 2'b00}; ws = {mb, 2'b00}; sl = sa; ss = sb;
        end
        for (int i = 0; i < int'(dd); i++) begin
            st = st | ws[0];
            ws = ws >> 1;
        end
        ws[0] = ws[0] | st;
        fl = sl ? (27'd0 - {1'b0, wl}) : {1'b0, wl};
        fs = ss ? (27'd0 - {1'b0, ws}) : {1'b0, ws};
        return mk(1'b0, el, fl, fs);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out, got no handshake, expected one (t=%0t)", name, $time);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one operand pair and returns one cycle after it is accepted; in_valid stays high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t e);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (in_ready) begin
                exp_q.push_back(e);
                next_cycle();
                return;
            end
            next_cycle();
        end
        timeout("send");
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) return;
            next_cycle();
            if (!rand_rdy) out_ready = 1'b1;
        end
        timeout("drain");
    endtask

    // Output monitor: pops the scoreboard on every output transfer and checks stability under stall.
    bit   prev_stall = 0;
    res_t held;
    always @(negedge CLK) begin
        if (!nRST) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) check("stall_hold", {1'b0, special, exp_out, frac1, frac2}, {1'b0, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got result %h, expected none", {special, exp_out, frac1, frac2});
                end else begin
                    check("result", {1'b0, special, exp_out, frac1, frac2}, {1'b0, exp_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = {special, exp_out, frac1, frac2};
        end
    end

    initial begin
        int accepts;
        int idx;
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, mk(1'b0, 8'h7F, 27'h2000000, 27'h2000000)};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, mk(1'b0, 8'h7F, 27'h2000000, 27'h6000000)};
        vecs[2]  = '{32'h3F800000, 32'h40000000, 1'b0, mk(1'b0, 8'h80, 27'h2000000, 27'h1000000)};
        vecs[3]  = '{32'h4E800000, 32'h3F800001, 1'b0, mk(1'b0, 8'h9D, 27'h2000000, 27'h0000001)};
        vecs[4]  = '{32'h7F800000, 32'h3F800000, 1'b0, mk(1'b1, 8'hFF, 27'h0, 27'h0)};
        vecs[5]  = '{32'hBF800000, 32'h3F800000, 1'b0, mk(1'b0, 8'h7F, 27'h6000000, 27'h2000000)};
        vecs[6]  = '{32'h4B800000, 32'h3F800001, 1'b0, mk(1'b0, 8'h97, 27'h2000000, 27'h0000003)};
        vecs[7]  = '{32'h4C800000, 32'h3F800000, 1'b0, mk(1'b0, 8'h99, 27'h2000000, 27'h0000001)};
        vecs[8]  = '{32'h3F800000, 32'h3FC00000, 1'b1, mk(1'b0, 8'h7F, 27'h2000000, 27'h5000000)};
        vecs[10] = '{32'h3F800000, 32'hFFC00000, 1'b0, mk(1'b1, 8'hFF, 27'h0, 27'h0)};
`ifdef FPU_ALIGN_DENORM_EN
        vecs[9]  = '{32'h3F800000, 32'h00400000, 1'b1, mk(1'b0, 8'h7F, 27'h2000000, 27'h7FFFFFF)};
        vecs[11] = '{32'h00000000, 32'h80000000, 1'b0, mk(1'b0, 8'h01, 27'h0, 27'h0)};
`else
        vecs[9]  = '{32'h3F800000, 32'h00400000, 1'b1, mk(1'b0, 8'h7F, 27'h2000000, 27'h0)};
        vecs[11] = '{32'h00000000, 32'h80000000, 1'b0, mk(1'b0, 8'h00, 27'h0, 27'h0)};
`endif

        nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; sub = 1'b0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {1'b0, special, exp_out, frac1, frac2}, 64'd0);
        nRST = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        next_cycle();

        // Latency: result visible two cycles after the operands were presented.
        send(vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].exp);
        in_valid = 1'b0;
        @(negedge CLK);
        check("lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge CLK);
        check("lat_2cyc", {63'd0, out_valid}, 64'd1);
        next_cycle();
        drain();

        // Vector table, back to back.
        for (int i = 0; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
        drain();

        // Backpressure: three pairs offered while out_ready is low for four cycles.
        out_ready = 1'b0; accepts = 0; idx = 0;
        op_a = vecs[0].a; op_b = vecs[0].b; sub = vecs[0].s; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (in_ready && idx < 3) begin
                exp_q.push_back(vecs[idx].exp);
                idx++;
                accepts++;
            end
            next_cycle();
            if (idx < 3) begin
                op_a = vecs[idx].a; op_b = vecs[idx].b; sub = vecs[idx].s;
            end
        end
        check("bp_accepts", 64'(accepts), 64'd2);
        @(negedge CLK);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        next_cycle();
        out_ready = 1'b1;
        send(vecs[2].a, vecs[2].b, vecs[2].s, vecs[2].exp);
        drain();

        // Reset with the pipeline full.
        out_ready = 1'b0;
        send(vecs[1].a, vecs[1].b, vecs[1].s, vecs[1].exp);
        send(vecs[2].a, vecs[2].b, vecs[2].s, vecs[2].exp);
        in_valid = 1'b0;
        @(negedge CLK);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        #10 nRST = 1'b1;
        @(negedge CLK);
        check("rst_rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_rel_out_valid", {63'd0, out_valid}, 64'd0);
        next_cycle();
        out_ready = 1'b1;

        // Random traffic with random backpressure; exponents kept near each other to exercise shifts.
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = {1'($urandom_range(0, 1)), ra[30:23] + 8'($urandom_range(0, 40)) - 8'd20, 23'($urandom)};
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        rand_rdy = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
